uart_tx_word_sequencer: RTL and testbench
=========================================

# uart_tx_word_sequencer

Parametrised byte sequencer feeding the UART transmit driver. On a `send` request it waits a programmable settle time, captures a word of up to `DATA_BYTES` bytes, and emits a runtime-selected number of bytes in either order. Each byte uses a `tx_start`/`tx_done` handshake with the driver, followed by a programmable inter-byte gap. It sits between result-producing logic (ALU, counters) and the UART TX driver, and generalises the fixed two-byte controller.

## Interface

- `DATA_BYTES`, default 4: width of `data_in` in bytes; legal range 1..8.
- `START_DELAY`, default 100: cycles between accepting `send` and capturing `data_in`; 0 is legal.
- `INTER_BYTE_DELAY`, default 1000000: idle cycles after each `tx_done` before the next byte; 0 is legal.
- `MSB_FIRST`, default 0: 0 sends byte 0 (bits 7:0) first; 1 sends the highest selected byte first.
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `send` in 1: request; sampled only in IDLE.
- `byte_count` in 4: number of bytes to send, sampled with `send`. 0 or values above `DATA_BYTES` mean `DATA_BYTES`.
- `data_in` in 8*DATA_BYTES: word to transmit.
- `tx_done` in 1: one-cycle pulse from the driver when the current byte has finished.
- `tx_data` out 8: byte presented to the driver.
- `tx_start` out 1: one-cycle pulse starting a byte.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the whole sequence has completed.

## Operation

- States: IDLE, START_WAIT, SEND, WAIT_DRV, GAP, and CHK_SEND when checksum is enabled.
- IDLE:
  - `send`=1 latches the effective count N and enters START_WAIT.
  - If `START_DELAY`=0, `data_in` is captured in the same cycle and the FSM goes straight to SEND.
- START_WAIT:
  - Lasts exactly `START_DELAY` cycles.
  - The data register loads `data_in` on every START_WAIT cycle, so the value present in the last START_WAIT cycle is the one sent.
  - Exits to SEND.
- SEND:
  - One cycle long; `tx_start`=1 and `tx_data` = the selected byte.
  - Goes to WAIT_DRV.
- Byte selection:
  - `MSB_FIRST`=0 sends byte indices 0..N-1.
  - `MSB_FIRST`=1 sends byte indices N-1..0.
  - Byte i is `data_in[8i+7:8i]`.
- WAIT_DRV:
  - Waits indefinitely for `tx_done`.
  - A `tx_done` in any other state is ignored.
- GAP:
  - Lasts `INTER_BYTE_DELAY` cycles; skipped when the parameter is 0.
  - Afterwards goes to SEND if bytes remain, otherwise IDLE with `done`=1 on the GAP exit cycle.
- `send` while busy is ignored and not queued.
- `tx_data` is registered and holds the last byte sent until the next SEND.

## Timing

- Reset values: state IDLE, `tx_data`=8'h00, `tx_start`=0, `busy`=0, `done`=0, timer 0, byte index 0.
- With `send` at cycle t, `tx_start` is high at cycle t+START_DELAY+1.
- With `tx_done` at cycle d:
  - the next `tx_start` is at d+INTER_BYTE_DELAY+1;
  - on the last byte, `done` is at d+INTER_BYTE_DELAY when INTER_BYTE_DELAY>0, and at d+1 when it is 0.
- `busy` rises the cycle after `send` and falls the cycle after `done`.
- Reset mid-sequence: outputs return to reset values on the next edge. No partial byte resumes, and `tx_start` is never asserted in the cycle after reset.
- Timer width is `$clog2(max(START_DELAY, INTER_BYTE_DELAY)+1)`, minimum 1. It clears on every state change.

## Configuration

- Macro: `UART_TX_SEQ_CHECKSUM_EN`.
- Defined:
  - After the last data byte's GAP, the FSM enters CHK_SEND and sends the XOR of all N transmitted bytes.
  - The checksum byte uses the same WAIT_DRV/GAP handshake, and `done` follows its GAP.
- Undefined: CHK_SEND and the XOR accumulator do not exist, and `done` follows the last data byte.

## Structure

- Package `uart_tx_pkg` holds:
  - the state enum `uart_tx_state_t`;
  - the constant `UART_MAX_BYTES`=8;
  - the function `eff_count(byte_count, DATA_BYTES)`.
- Sub-module `uart_hold_timer`: clears on `clear`, increments otherwise, and asserts `expired` when the count equals a `limit` input. It is shared by START_WAIT and GAP.

## Test plan

- Basic order:
  - Stimulus: DATA_BYTES=4, MSB_FIRST=0, START_DELAY=3, INTER_BYTE_DELAY=5, byte_count=0, data_in=32'hA1B2C3D4, driver returning `tx_done` 10 cycles after each `tx_start`.
  - Response: bytes D4, C3, B2, A1; first `tx_start` at t+4; gaps of exactly 5 cycles; a single `done`.
- Reverse and short count:
  - Stimulus: MSB_FIRST=1, byte_count=2, data_in=32'hA1B2C3D4.
  - Response: bytes C3 then D4 only.
- Late capture:
  - Stimulus: data_in changes from 32'h11111111 to 32'h22222222 in the last START_WAIT cycle.
  - Response: all bytes are 8'h22.
- Ignored inputs:
  - Stimulus: `send` pulsed during WAIT_DRV; a stray `tx_done` in GAP.
  - Response: no restart, no extra bytes, identical timing.
- Zero delays and reset:
  - Stimulus: START_DELAY=0, INTER_BYTE_DELAY=0, byte_count=1; then reset asserted during WAIT_DRV of a second request.
  - Response: `tx_start` the cycle after `send`, `done` the cycle after `tx_done`; after reset, `busy`=0, `tx_data`=00 and no further `tx_start`.
- Checksum (`UART_TX_SEQ_CHECKSUM_EN` defined):
  - Stimulus: data_in=32'h01020408, byte_count=4.
  - Response: five bytes 08, 04, 02, 01, 0F, with `done` after the fifth.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit word sequencer.
//   uart_tx_state_t : sequencer FSM states. CHK_SEND exists only when
//                     UART_TX_SEQ_CHECKSUM_EN is defined.
//   UART_MAX_BYTES  : widest word the sequencer can be built for.
//   eff_count()     : turns the requested byte count into the count actually sent.
//   pick_byte()     : extracts one byte lane from a word padded to UART_MAX_BYTES.
package uart_tx_pkg;

  localparam int UART_MAX_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE,
    START_WAIT,
    SEND,
    WAIT_DRV,
    GAP
`ifdef UART_TX_SEQ_CHECKSUM_EN
    , CHK_SEND
`endif
  } uart_tx_state_t;

  // A count of zero, or one larger than the word, means "send the whole word".
  function automatic logic [3:0] eff_count(input logic [3:0] byte_count,
                                           input int         data_bytes);
    if (byte_count == 4'd0 || int'(byte_count) > data_bytes) return 4'(data_bytes);
    return byte_count;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [8*UART_MAX_BYTES-1:0] word,
                                           input logic [2:0]                  idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_hold_timer.sv
// Hold timer shared by the settle wait and the inter-byte gap.
//   clock, reset : clock and synchronous active-high reset
//   clear        : forces the count back to zero (has priority over counting)
//   limit        : terminal count for the current wait
//   count        : current count
//   expired      : count equals limit
module uart_hold_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             expired
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (reset || clear) count <= '0;
    else                count <= count + WIDTH'(1);
  end

  assign expired = (count == limit);

endmodule

// File: rtl/uart_tx_word_sequencer.sv
// Byte sequencer feeding the UART TX driver. On `send` it waits START_DELAY
// cycles, captures `data_in`, then emits the selected number of bytes with a
// tx_start/tx_done handshake and an INTER_BYTE_DELAY gap after each byte.
// Optional macro UART_TX_SEQ_CHECKSUM_EN appends the XOR of all sent bytes.
//   clock, reset : clock and synchronous active-high reset
//   send         : request, sampled only in IDLE
//   byte_count   : bytes to send (0 or > DATA_BYTES means DATA_BYTES)
//   data_in      : word to transmit, byte i is data_in[8i+7:8i]
//   tx_done      : driver pulse, honoured only in WAIT_DRV
//   tx_data      : registered byte for the driver, holds until the next byte
//   tx_start     : one-cycle pulse starting a byte
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse in the final cycle of the sequence
module uart_tx_word_sequencer
  import uart_tx_pkg::*;
#(
  parameter int DATA_BYTES       = 4,
  parameter int START_DELAY      = 100,
  parameter int INTER_BYTE_DELAY = 1000000,
  parameter int MSB_FIRST        = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    send,
  input  logic [3:0]              byte_count,
  input  logic [8*DATA_BYTES-1:0] data_in,
  input  logic                    tx_done,
  output logic [7:0]              tx_data,
  output logic                    tx_start,
  output logic                    busy,
  output logic                    done
);

  localparam int MAX_DELAY = (START_DELAY > INTER_BYTE_DELAY) ? START_DELAY : INTER_BYTE_DELAY;
  localparam int TW        = (MAX_DELAY > 0) ? $clog2(MAX_DELAY + 1) : 1;
  // Timer runs 0..limit, so a wait of D cycles uses limit D-1.
  localparam int SD_LIM    = (START_DELAY > 0) ? START_DELAY - 1 : 0;
  // A zero gap still gives the final byte one GAP cycle to carry `done`.
  localparam int GAP_LIM   = (INTER_BYTE_DELAY > 0) ? INTER_BYTE_DELAY - 1 : 0;
  localparam int GAP_PRE   = (GAP_LIM > 0) ? GAP_LIM - 1 : 0;

  uart_tx_state_t          state;
  logic [8*DATA_BYTES-1:0] data_reg;
  logic [3:0]              n_reg;
  logic [3:0]              byte_idx;   // bytes already started
`ifdef UART_TX_SEQ_CHECKSUM_EN
  logic [7:0]              chk;
  logic                    chk_done;
`endif

  logic [TW-1:0]               timer_count;
  logic [TW-1:0]               timer_limit;
  logic                        timer_clear;
  logic                        timer_expired;
  logic [8*UART_MAX_BYTES-1:0] src_word;
  logic [3:0]                  n_sel;
  logic [2:0]                  sel_idx;
  logic [7:0]                  next_byte;
  logic                        more_data;
  logic                        final_byte;

  // Timer only runs in the two timed states and restarts whenever they end.
  assign timer_limit = (state == START_WAIT) ? TW'(SD_LIM) : TW'(GAP_LIM);
  assign timer_clear = !(state == START_WAIT || state == GAP) || timer_expired;

  uart_hold_timer #(.WIDTH(TW)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .limit   (timer_limit),
    .count   (timer_count),
    .expired (timer_expired)
  );

  // The first byte comes straight from data_in so the value present in the
  // capture cycle is the one sent; later bytes come from data_reg.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    src_word   = '0;
    src_word[8*DATA_BYTES-1:0] = (state == IDLE || state == START_WAIT) ? data_in : data_reg;
    n_sel      = (state == IDLE) ? eff_count(byte_count, DATA_BYTES) : n_reg;
    sel_idx    = (MSB_FIRST != 0) ? 3'(n_sel - 4'd1 - byte_idx) : byte_idx[2:0];
    next_byte  = pick_byte(src_word, sel_idx);
    more_data  = (byte_idx < n_reg);
`ifdef UART_TX_SEQ_CHECKSUM_EN
    final_byte = !more_data && chk_done;
`else
    final_byte = !more_data;
`endif
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      data_reg <= '0;
      n_reg    <= '0;
      byte_idx <= '0;
      tx_data  <= 8'h00;
      tx_start <= 1'b0;
      done     <= 1'b0;
`ifdef UART_TX_SEQ_CHECKSUM_EN
      chk      <= 8'h00;
      chk_done <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (send) begin
            n_reg <= eff_count(byte_count, DATA_BYTES);
`ifdef UART_TX_SEQ_CHECKSUM_EN
            chk      <= 8'h00;
            chk_done <= 1'b0;
`endif
            if (START_DELAY == 0) begin
              data_reg <= data_in;
              state    <= SEND;
              tx_start <= 1'b1;
              tx_data  <= next_byte;
            end else begin
              state <= START_WAIT;
            end
          end
        end
        START_WAIT: begin
          data_reg <= data_in;
          if (timer_expired) begin
            state    <= SEND;
            tx_start <= 1'b1;
            tx_data  <= next_byte;
          end
        end
        SEND: begin
          byte_idx <= byte_idx + 4'd1;
`ifdef UART_TX_SEQ_CHECKSUM_EN
          chk <= chk ^ tx_data;
`endif
          state <= WAIT_DRV;
        end
`ifdef UART_TX_SEQ_CHECKSUM_EN
        CHK_SEND: begin
          chk_done <= 1'b1;
          state    <= WAIT_DRV;
        end
`endif
        WAIT_DRV: begin
          if (tx_done) begin
            if (!final_byte && INTER_BYTE_DELAY == 0) begin
              if (more_data) begin
                state    <= SEND;
                tx_start <= 1'b1;
                tx_data  <= next_byte;
              end
`ifdef UART_TX_SEQ_CHECKSUM_EN
              else begin
                state    <= CHK_SEND;
                tx_start <= 1'b1;
                tx_data  <= chk;
              end
`endif
            end else begin
              state <= GAP;
              // One-cycle final GAP: `done` lands in it directly.
              if (final_byte && GAP_LIM == 0) done <= 1'b1;
            end
          end
        end
        GAP: begin
          if (timer_expired) begin
            if (final_byte) begin
              state    <= IDLE;
              byte_idx <= '0;
            end else if (more_data) begin
              state    <= SEND;
              tx_start <= 1'b1;
              tx_data  <= next_byte;
            end
`ifdef UART_TX_SEQ_CHECKSUM_EN
            else begin
              state    <= CHK_SEND;
              tx_start <= 1'b1;
              tx_data  <= chk;
            end
`endif
          end else if (final_byte && GAP_LIM != 0 && timer_count == TW'(GAP_PRE)) begin
            // Registered `done` is raised one cycle early so it sits in the
            // last GAP cycle.
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_word_sequencer.sv
// Bench for uart_tx_word_sequencer. Two instances share one clock:
//   unit 0: DATA_BYTES=4, START_DELAY=3, INTER_BYTE_DELAY=5, MSB_FIRST=0
//   unit 1: DATA_BYTES=4, START_DELAY=0, INTER_BYTE_DELAY=0, MSB_FIRST=1
// A driver model answers each tx_start with tx_done 10 cycles later. Expected
// bytes go into a per-unit queue when a request is issued and are popped on
// every tx_start. Honours UART_TX_SEQ_CHECKSUM_EN for the trailing XOR byte.
module tb_uart_tx_word_sequencer;

  logic        clock = 1'b0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  logic        reset_s    [2];
  logic        send_s     [2];
  logic [3:0]  bc_s       [2];
  logic [31:0] data_in_s  [2];
  logic        resp_done  [2];
  logic        stray_done [2];
  wire         tx_done_w  [2];
  wire  [7:0]  tx_data_w  [2];
  wire         tx_start_w [2];
  wire         busy_w     [2];
  wire         done_w     [2];

  logic [7:0]  exp_q    [2][$];
  int          starts_q [2][$];
  int          done_cnt [2];
  int          done_cyc [2];
  int          fall_cyc [2];

  assign tx_done_w[0] = resp_done[0] | stray_done[0];
  assign tx_done_w[1] = resp_done[1] | stray_done[1];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_tx_word_sequencer #(
    .DATA_BYTES(4), .START_DELAY(3), .INTER_BYTE_DELAY(5), .MSB_FIRST(0)
  ) dut_a (
    .clock(clock), .reset(reset_s[0]), .send(send_s[0]), .byte_count(bc_s[0]),
    .data_in(data_in_s[0]), .tx_done(tx_done_w[0]), .tx_data(tx_data_w[0]),
    .tx_start(tx_start_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  uart_tx_word_sequencer #(
    .DATA_BYTES(4), .START_DELAY(0), .INTER_BYTE_DELAY(0), .MSB_FIRST(1)
  ) dut_b (
    .clock(clock), .reset(reset_s[1]), .send(send_s[1]), .byte_count(bc_s[1]),
    .data_in(data_in_s[1]), .tx_done(tx_done_w[1]), .tx_data(tx_data_w[1]),
    .tx_start(tx_start_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Driver model plus output monitor for one unit; samples on the falling edge.
  task automatic agent(input int u);
    int countdown = 0;
    logic prev_busy = 1'b0;
    forever begin
      @(negedge clock);
      resp_done[u] = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) resp_done[u] = 1'b1;
      end
      if (tx_start_w[u] === 1'b1) begin
        countdown = 10;
        starts_q[u].push_back(cyc);
        check($sformatf("u%0d_sb_nonempty", u), 32'(exp_q[u].size() != 0), 1);
        if (exp_q[u].size() != 0)
          check($sformatf("u%0d_byte%0d", u, starts_q[u].size() - 1),
                tx_data_w[u], exp_q[u].pop_front());
      end
      if (done_w[u] === 1'b1) begin
        done_cnt[u]++;
        done_cyc[u] = cyc;
      end
      if (prev_busy === 1'b1 && busy_w[u] === 1'b0) fall_cyc[u] = cyc;
      prev_busy = busy_w[u];
    end
  endtask

  // One request on unit u. late: data_in switches in the last START_WAIT cycle.
  // disturb: send in WAIT_DRV and a stray tx_done in the first GAP.
  // cut: reset during WAIT_DRV of the first byte.
  task automatic run_seq(input int u, input string tag, input logic [3:0] bc,
                         input logic [31:0] word, input bit late, input logic [31:0] late_word,
                         input bit disturb, input bit cut);
    int t, n, k, first, pitch, tail, exp_done;
    logic [31:0] w;
    logic [7:0]  x, b;
    first = (u == 0) ? 4 : 1;     // START_DELAY + 1
    pitch = (u == 0) ? 16 : 11;   // 10-cycle driver + gap + SEND cycle
    tail  = (u == 0) ? 15 : 11;   // 10-cycle driver + max(gap, 1)
    n = (bc == 4'd0 || bc > 4'd4) ? 4 : int'(bc);
    w = late ? late_word : word;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = (u == 1) ? w[8*(n-1-i) +: 8] : w[8*i +: 8];
      x ^= b;
      if (!cut || i == 0) exp_q[u].push_back(b);
    end
    k = n;
`ifdef UART_TX_SEQ_CHECKSUM_EN
    if (!cut) exp_q[u].push_back(x);
    k = n + 1;
`endif
    starts_q[u].delete();
    done_cnt[u] = 0;
    done_cyc[u] = -1;
    fall_cyc[u] = -1;

    @(negedge clock);
    t = cyc;
    check({tag, "_busy_before"}, 32'(busy_w[u]), 0);
    send_s[u] = 1'b1;
    bc_s[u] = bc;
    data_in_s[u] = word;
    wait_until(t + 1);
    send_s[u] = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy_w[u]), 1);
    if (late) begin
      wait_until(t + first - 1);
      data_in_s[u] = late_word;
    end
    if (disturb) begin
      wait_until(t + first + 3);  send_s[u] = 1'b1;
      wait_until(t + first + 4);  send_s[u] = 1'b0;
      wait_until(t + first + 13); stray_done[u] = 1'b1;
      wait_until(t + first + 14); stray_done[u] = 1'b0;
    end
    if (cut) begin
      wait_until(t + first + 3); reset_s[u] = 1'b1;
      wait_until(t + first + 4); reset_s[u] = 1'b0;
      check({tag, "_rst_busy"},     32'(busy_w[u]), 0);
      check({tag, "_rst_tx_data"},  32'(tx_data_w[u]), 0);
      check({tag, "_rst_tx_start"}, 32'(tx_start_w[u]), 0);
      check({tag, "_rst_done"},     32'(done_w[u]), 0);
      wait_until(t + first + 40);
      check({tag, "_start_count"}, starts_q[u].size(), 1);
      check({tag, "_done_count"},  done_cnt[u], 0);
      check({tag, "_sb_drained"},  exp_q[u].size(), 0);
    end else begin
      exp_done = t + first + pitch * (k - 1) + tail;
      wait_until(exp_done + 8);
      check({tag, "_start_count"}, starts_q[u].size(), k);
      for (int i = 0; i < starts_q[u].size() && i < k; i++)
        check($sformatf("%s_start%0d_cycle", tag, i), starts_q[u][i], t + first + pitch * i);
      check({tag, "_done_count"}, done_cnt[u], 1);
      check({tag, "_done_cycle"}, done_cyc[u], exp_done);
      check({tag, "_busy_fall"},  fall_cyc[u], exp_done + 1);
      check({tag, "_sb_drained"}, exp_q[u].size(), 0);
      check({tag, "_busy_after"}, 32'(busy_w[u]), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      reset_s[u] = 1'b1;
      send_s[u] = 1'b0;
      bc_s[u] = 4'd0;
      data_in_s[u] = 32'h0;
      resp_done[u] = 1'b0;
      stray_done[u] = 1'b0;
      done_cnt[u] = 0;
      done_cyc[u] = -1;
      fall_cyc[u] = -1;
    end
    fork
      agent(0);
      agent(1);
    join_none
    repeat (3) @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d_reset_tx_data", u),  32'(tx_data_w[u]), 0);
      check($sformatf("u%0d_reset_tx_start", u), 32'(tx_start_w[u]), 0);
      check($sformatf("u%0d_reset_busy", u),     32'(busy_w[u]), 0);
      check($sformatf("u%0d_reset_done", u),     32'(done_w[u]), 0);
    end
    reset_s[0] = 1'b0;
    reset_s[1] = 1'b0;
    repeat (2) @(negedge clock);

    run_seq(0, "basic",    4'd0, 32'hA1B2C3D4, 1'b0, 32'h0,        1'b0, 1'b0);
    run_seq(0, "late",     4'd0, 32'h11111111, 1'b1, 32'h22222222, 1'b0, 1'b0);
    run_seq(0, "ignored",  4'd4, 32'hA1B2C3D4, 1'b0, 32'h0,        1'b1, 1'b0);
    run_seq(0, "xorword",  4'd4, 32'h01020408, 1'b0, 32'h0,        1'b0, 1'b0);
    run_seq(0, "over",     4'd9, 32'h0F1E2D3C, 1'b0, 32'h0,        1'b0, 1'b0);
    run_seq(0, "three",    4'd3, 32'h5566AA99, 1'b0, 32'h0,        1'b0, 1'b0);
    run_seq(1, "reverse2", 4'd2, 32'hA1B2C3D4, 1'b0, 32'h0,        1'b0, 1'b0);
    run_seq(1, "zero1",    4'd1, 32'h5A5A5A77, 1'b0, 32'h0,        1'b0, 1'b0);
    run_seq(1, "cut",      4'd4, 32'h11223344, 1'b0, 32'h0,        1'b0, 1'b1);
    run_seq(1, "recover",  4'd0, 32'hA1B2C3D4, 1'b0, 32'h0,        1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
